// File: rtl/can_timing_ctrl.sv
// CAN bit-timing controller: owns the bit-timing configuration, holds the
// time-quantum generator in reset while configuring, and performs bus integration.
module can_timing_ctrl #(
    parameter logic [5:0] DEF_BRP   = 6'd3,
    parameter logic [3:0] DEF_TSEG1 = 4'd10,
    parameter logic [2:0] DEF_TSEG2 = 3'd3,
    parameter logic [1:0] DEF_SJW   = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr,
    input  logic [14:0] cfg_wdata,
    input  logic        cfg_mode_req,
    input  logic        rx,
    input  logic        bit_tick,
    input  logic        sample_point,
    output logic [5:0]  brp,
    output logic [3:0]  tseg1,
    output logic [2:0]  tseg2,
    output logic [1:0]  sjw,
    output logic        gen_rst_n,
    output logic [1:0]  state,
    output logic [3:0]  integ_cnt,
    output logic        bus_idle,
    output logic        cfg_ack,
    output logic        cfg_err
);

    // state      | meaning
    // CONFIG     | generator held in reset, configuration writes accepted
    // INTEGRATE  | counting consecutive recessive samples before joining the bus
    // ACTIVE     | bus idle detected, normal operation
    localparam logic [1:0] ST_CONFIG    = 2'd0;
    localparam logic [1:0] ST_INTEGRATE = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

    localparam logic [3:0] INTEG_DONE = 4'd11;

    logic [5:0] wr_brp;
    logic [3:0] wr_tseg1;
    logic [2:0] wr_tseg2;
    logic [1:0] wr_sjw;
    logic       wr_valid;
    logic       wr_accept;
    logic [1:0] state_nxt;
    logic [3:0] cnt_nxt;

    assign wr_brp    = cfg_wdata[5:0];
    assign wr_tseg1  = cfg_wdata[9:6];
    assign wr_tseg2  = cfg_wdata[12:10];
    assign wr_sjw    = cfg_wdata[14:13];
    assign wr_valid  = (wr_tseg1 != 4'd0) && ({1'b0, wr_sjw} <= wr_tseg2);
    assign wr_accept = cfg_wr && (state == ST_CONFIG) && wr_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = integ_cnt;
        case (state)
            ST_CONFIG: begin
                cnt_nxt = 4'd0;
                if (!cfg_mode_req)
                    state_nxt = ST_INTEGRATE;
            end
            ST_INTEGRATE: begin
                // A configuration request aborts integration even on the completing sample.
                if (cfg_mode_req) begin
                    state_nxt = ST_CONFIG;
                    cnt_nxt   = 4'd0;
                end else if (sample_point) begin
                    if (!rx) begin
                        cnt_nxt = 4'd0;
                    end else if (integ_cnt >= INTEG_DONE - 4'd1) begin
                        cnt_nxt   = INTEG_DONE;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        cnt_nxt = integ_cnt + 4'd1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (cfg_mode_req && bit_tick) begin
                    state_nxt = ST_CONFIG;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = ST_CONFIG;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_CONFIG;
            gen_rst_n <= 1'b0;
            brp       <= DEF_BRP;
            tseg1     <= DEF_TSEG1;
            tseg2     <= DEF_TSEG2;
            sjw       <= DEF_SJW;
            integ_cnt <= 4'd0;
            bus_idle  <= 1'b0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            integ_cnt <= cnt_nxt;
            // Derived from the next state so it tracks state without a cycle of lag.
            gen_rst_n <= (state_nxt == ST_INTEGRATE) || (state_nxt == ST_ACTIVE);
            bus_idle  <= (state_nxt == ST_ACTIVE);
            cfg_ack   <= wr_accept;
            if (cfg_wr)
                cfg_err <= !wr_accept;
            if (wr_accept) begin
                brp   <= wr_brp;
                tseg1 <= wr_tseg1;
                tseg2 <= wr_tseg2;
                sjw   <= wr_sjw;
            end
        end
    end

endmodule

// File: tb/tb_can_timing_ctrl.sv
// Directed bench for can_timing_ctrl: configuration writes, bus integration,
// graceful exit from ACTIVE and reset override.
module tb_can_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [14:0] cfg_wdata;
    logic        cfg_mode_req;
    logic        rx;
    logic        bit_tick;
    logic        sample_point;
    logic [5:0]  brp;
    logic [3:0]  tseg1;
    logic [2:0]  tseg2;
    logic [1:0]  sjw;
    logic        gen_rst_n;
    logic [1:0]  state;
    logic [3:0]  integ_cnt;
    logic        bus_idle;
    logic        cfg_ack;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;
    logic [14:0] e_fields;

    can_timing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_wdata(cfg_wdata),
        .cfg_mode_req(cfg_mode_req), .rx(rx), .bit_tick(bit_tick),
        .sample_point(sample_point), .brp(brp), .tseg1(tseg1), .tseg2(tseg2),
        .sjw(sjw), .gen_rst_n(gen_rst_n), .state(state), .integ_cnt(integ_cnt),
        .bus_idle(bus_idle), .cfg_ack(cfg_ack), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input int b, input int t1, input int t2, input int s);
        logic [14:0] v;
        v = {s[1:0], t2[2:0], t1[3:0], b[5:0]};
        return v;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_mode_req = 1'b1; cfg_wr = 1'b0; cfg_wdata = '0;
        rx = 1'b1; bit_tick = 1'b0; sample_point = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        e_fields = pack(3, 10, 3, 0);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (gen_rst_n !== 1'b0) begin failures++; $display("FAIL reset_gen_rst_n got=%b exp=0", gen_rst_n); end
        checks++; if ({sjw, tseg2, tseg1, brp} !== e_fields) begin failures++; $display("FAIL reset_fields got=%h exp=%h", {sjw, tseg2, tseg1, brp}, e_fields); end
        checks++; if ({cfg_err, cfg_ack, bus_idle} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {cfg_err, cfg_ack, bus_idle}); end
        checks++; if (integ_cnt !== 4'd0) begin failures++; $display("FAIL reset_integ_cnt got=%0d exp=0", integ_cnt); end
    endtask

    task automatic test_cfg_write();
        cfg_wr = 1'b1; cfg_wdata = pack(7, 5, 2, 1);
        tick();
        cfg_wr = 1'b0;
        e_fields = pack(7, 5, 2, 1);
        checks++; if ({sjw, tseg2, tseg1, brp} !== e_fields) begin failures++; $display("FAIL wr_valid_fields got=%h exp=%h", {sjw, tseg2, tseg1, brp}, e_fields); end
        checks++; if ({cfg_ack, cfg_err} !== 2'b10) begin failures++; $display("FAIL wr_valid_ack got=%b exp=10", {cfg_ack, cfg_err}); end
        tick();
        checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_one_pulse got=%b exp=0", cfg_ack); end
        // sjw 3 > tseg2 2 is rejected
        cfg_wr = 1'b1; cfg_wdata = pack(9, 6, 2, 3);
        tick();
        cfg_wr = 1'b0;
        checks++; if ({sjw, tseg2, tseg1, brp} !== e_fields) begin failures++; $display("FAIL wr_sjw_bad_fields got=%h exp=%h", {sjw, tseg2, tseg1, brp}, e_fields); end
        checks++; if ({cfg_ack, cfg_err} !== 2'b01) begin failures++; $display("FAIL wr_sjw_bad_err got=%b exp=01", {cfg_ack, cfg_err}); end
        // tseg1 0 is rejected
        cfg_wr = 1'b1; cfg_wdata = pack(9, 0, 4, 0);
        tick();
        cfg_wr = 1'b0;
        checks++; if ({sjw, tseg2, tseg1, brp, cfg_ack, cfg_err} !== {e_fields, 2'b01}) begin failures++; $display("FAIL wr_tseg1_zero got=%h exp=%h", {sjw, tseg2, tseg1, brp, cfg_ack, cfg_err}, {e_fields, 2'b01}); end
        // boundaries tseg1 1, sjw == tseg2 are legal and clear the error
        cfg_wr = 1'b1; cfg_wdata = pack(9, 1, 2, 2);
        tick();
        cfg_wr = 1'b0;
        e_fields = pack(9, 1, 2, 2);
        checks++; if ({sjw, tseg2, tseg1, brp, cfg_ack, cfg_err} !== {e_fields, 2'b10}) begin failures++; $display("FAIL wr_boundary_ok got=%h exp=%h", {sjw, tseg2, tseg1, brp, cfg_ack, cfg_err}, {e_fields, 2'b10}); end
    endtask

    task automatic test_integrate();
        // write and leave CONFIG on the same edge
        cfg_wr = 1'b1; cfg_wdata = pack(7, 5, 2, 1); cfg_mode_req = 1'b0;
        tick();
        cfg_wr = 1'b0;
        e_fields = pack(7, 5, 2, 1);
        checks++; if ({state, gen_rst_n, cfg_ack, integ_cnt} !== {2'd1, 1'b1, 1'b1, 4'd0}) begin failures++; $display("FAIL same_edge_exit got=%h exp=%h", {state, gen_rst_n, cfg_ack, integ_cnt}, {2'd1, 1'b1, 1'b1, 4'd0}); end
        checks++; if ({sjw, tseg2, tseg1, brp} !== e_fields) begin failures++; $display("FAIL same_edge_fields got=%h exp=%h", {sjw, tseg2, tseg1, brp}, e_fields); end
        rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample_point = 1'b1; tick();
            sample_point = 1'b0; tick();
        end
        checks++; if ({state, integ_cnt} !== {2'd1, 4'd10}) begin failures++; $display("FAIL integ_ten got=%h exp=%h", {state, integ_cnt}, {2'd1, 4'd10}); end
        rx = 1'b0; sample_point = 1'b1; tick();
        sample_point = 1'b0; rx = 1'b1;
        checks++; if (integ_cnt !== 4'd0) begin failures++; $display("FAIL integ_dominant got=%0d exp=0", integ_cnt); end
        for (int i = 0; i < 10; i++) begin
            sample_point = 1'b1; tick();
        end
        checks++; if ({state, integ_cnt, bus_idle} !== {2'd1, 4'd10, 1'b0}) begin failures++; $display("FAIL integ_before_done got=%h exp=%h", {state, integ_cnt, bus_idle}, {2'd1, 4'd10, 1'b0}); end
        tick();
        checks++; if ({state, integ_cnt, bus_idle, gen_rst_n} !== {2'd2, 4'd11, 1'b1, 1'b1}) begin failures++; $display("FAIL integ_done got=%h exp=%h", {state, integ_cnt, bus_idle, gen_rst_n}, {2'd2, 4'd11, 1'b1, 1'b1}); end
        tick();
        sample_point = 1'b0;
        checks++; if ({state, integ_cnt} !== {2'd2, 4'd11}) begin failures++; $display("FAIL integ_saturate got=%h exp=%h", {state, integ_cnt}, {2'd2, 4'd11}); end
    endtask

    task automatic test_active_exit();
        cfg_wr = 1'b1; cfg_wdata = pack(1, 2, 3, 0);
        tick();
        cfg_wr = 1'b0;
        checks++; if ({sjw, tseg2, tseg1, brp, cfg_err, cfg_ack} !== {e_fields, 2'b10}) begin failures++; $display("FAIL active_wr_ignored got=%h exp=%h", {sjw, tseg2, tseg1, brp, cfg_err, cfg_ack}, {e_fields, 2'b10}); end
        cfg_mode_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({state, bus_idle, gen_rst_n} !== {2'd2, 1'b1, 1'b1}) begin failures++; $display("FAIL active_pending_%0d got=%h exp=%h", i, {state, bus_idle, gen_rst_n}, {2'd2, 1'b1, 1'b1}); end
        end
        bit_tick = 1'b1; tick();
        bit_tick = 1'b0;
        checks++; if ({state, gen_rst_n, bus_idle, integ_cnt} !== {2'd0, 1'b0, 1'b0, 4'd0}) begin failures++; $display("FAIL active_exit got=%h exp=%h", {state, gen_rst_n, bus_idle, integ_cnt}, {2'd0, 1'b0, 1'b0, 4'd0}); end
    endtask

    task automatic test_integrate_abort_reset();
        // clear the sticky error with a good write, then enter INTEGRATE
        cfg_wr = 1'b1; cfg_wdata = pack(5, 4, 3, 2);
        tick();
        cfg_wr = 1'b0; cfg_mode_req = 1'b0;
        e_fields = pack(5, 4, 3, 2);
        tick();
        checks++; if ({state, cfg_err} !== {2'd1, 1'b0}) begin failures++; $display("FAIL enter_integ got=%h exp=%h", {state, cfg_err}, {2'd1, 1'b0}); end
        cfg_wr = 1'b1; cfg_wdata = pack(2, 3, 1, 1);
        tick();
        cfg_wr = 1'b0;
        checks++; if ({sjw, tseg2, tseg1, brp, cfg_err, cfg_ack, state} !== {e_fields, 2'b10, 2'd1}) begin failures++; $display("FAIL integ_wr_ignored got=%h exp=%h", {sjw, tseg2, tseg1, brp, cfg_err, cfg_ack, state}, {e_fields, 2'b10, 2'd1}); end
        rx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample_point = 1'b1; tick();
        end
        checks++; if (integ_cnt !== 4'd6) begin failures++; $display("FAIL integ_six got=%0d exp=6", integ_cnt); end
        rst_n = 1'b0; cfg_wr = 1'b1; cfg_wdata = pack(8, 8, 4, 1);
        tick();
        rst_n = 1'b1; cfg_wr = 1'b0; sample_point = 1'b0; cfg_mode_req = 1'b1;
        e_fields = pack(3, 10, 3, 0);
        checks++; if ({state, gen_rst_n, integ_cnt, bus_idle, cfg_ack, cfg_err} !== {2'd0, 1'b0, 4'd0, 3'b000}) begin failures++; $display("FAIL midinteg_reset got=%h exp=%h", {state, gen_rst_n, integ_cnt, bus_idle, cfg_ack, cfg_err}, {2'd0, 1'b0, 4'd0, 3'b000}); end
        checks++; if ({sjw, tseg2, tseg1, brp} !== e_fields) begin failures++; $display("FAIL midinteg_reset_fields got=%h exp=%h", {sjw, tseg2, tseg1, brp}, e_fields); end
        // config request wins over the completing sample
        cfg_mode_req = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            sample_point = 1'b1; tick();
        end
        cfg_mode_req = 1'b1; tick();
        sample_point = 1'b0;
        checks++; if ({state, integ_cnt, bus_idle, gen_rst_n} !== {2'd0, 4'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL abort_priority got=%h exp=%h", {state, integ_cnt, bus_idle, gen_rst_n}, {2'd0, 4'd0, 1'b0, 1'b0}); end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_integrate();
        test_active_exit();
        test_integrate_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
